// File: rtl/nbj_pkg.sv
// Shared types and constants for the nbj redirect controller slice.
package nbj_pkg;

  localparam int PC_W  = 32;
  localparam int TAG_W = 3;

  localparam logic [2:0] BR_JALR = 3'd3;
  localparam logic [2:0] BR_CALL = 3'd4;
  localparam logic [2:0] BR_RET  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  // Classifies a block type into its effect on the return-address-stack pointer.
  function automatic logic [1:0] ras_action(input logic [2:0] br_type);
    case (br_type)
      BR_CALL: ras_action = 2'b01;
      BR_RET:  ras_action = 2'b10;
      BR_JALR: ras_action = 2'b00;
      default: ras_action = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/nbj_ckpt_fifo.sv
// In-order checkpoint FIFO of post-block RAS pointers, with truncate-to-tag on
// a backend correction and a live-tag check against the in-flight window.
module nbj_ckpt_fifo
  import nbj_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          trunc,
  input  logic [AW-1:0] tag,
  output logic [DW-1:0] tag_data,
  output logic          tag_live,
  output logic [AW-1:0] wr_ptr,
  output logic [AW:0]   count,
  output logic          full
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_after;
  logic [AW-1:0] offset;
  logic [AW:0]   count_after;
  logic          pop_eff;

  // The retire is applied before the live check so a same-cycle commit and
  // correction see the window the commit leaves behind.
  always_comb begin
    pop_eff     = pop && (count != '0);
    rd_after    = rd_ptr + AW'(pop_eff);
    count_after = count - (AW+1)'(pop_eff);
    offset      = tag - rd_after;
    tag_live    = (count_after != '0) && ({1'b0, offset} < count_after);
  end

  assign tag_data = mem[tag];
  assign full     = (count == (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_after;
      if (trunc) begin
        if (tag_live) begin
          wr_ptr <= tag + AW'(1);
          count  <= {1'b0, offset} + (AW+1)'(1);
        end else begin
          count  <= count_after;
        end
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        count <= count_after + (AW+1)'(push);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !trunc) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/nbj_redirect_ctrl.sv
// Fetch-PC sequencer around the nbj next-PC datapath: source arbitration,
// RAS pointer ownership, and checkpoint-based recovery with a fetch flush.
module nbj_redirect_ctrl
  import nbj_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = 32'h0,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              CKPT_DEPTH   = 1 << TAG_W,
  parameter int              RAS_DEPTH    = 8,
  localparam int             CKPT_AW      = $clog2(CKPT_DEPTH),
  localparam int             RAS_AW       = $clog2(RAS_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_fetchReady,
  input  logic               i_predValid,
  input  logic [PC_W-1:0]    i_predPc_32,
  input  logic [2:0]         i_predType_3,
  input  logic [4:0]         i_blockSize_5,
  input  logic               i_commitValid,
  input  logic               i_correctValid,
  input  logic [PC_W-1:0]    i_correctPc_32,
  input  logic [CKPT_AW-1:0] i_correctTag_3,
  output logic               o_fetchValid,
  output logic [PC_W-1:0]    o_fetchPc_32,
  output logic [CKPT_AW-1:0] o_fetchTag_3,
  output logic               o_rasPush,
  output logic               o_rasPop,
  output logic [RAS_AW-1:0]  o_rasPtr_3,
  output logic               o_flushing,
  output logic               o_ckptFull,
  output logic               o_tagErr
);

  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t              state;
  state_t              state_nxt;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic [FLUSH_W-1:0]  flush_cnt_nxt;
  logic [PC_W-1:0]     pc;
  logic [RAS_AW-1:0]   ras_ptr;
  logic [RAS_AW-1:0]   ras_upd;
  logic                fetch_valid;
  logic                fire;
  logic [1:0]          action;
  logic [RAS_AW-1:0]   ckpt_data;
  logic                ckpt_live;
  logic [CKPT_AW:0]    ckpt_count;
  logic                ckpt_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // A correction from any state (re)starts the flush window.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if (i_correctValid) begin
      state_nxt     = FLUSH;
      flush_cnt_nxt = FLUSH_W'(FLUSH_CYCLES - 1);
    end else begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = RUN;
        FLUSH: begin
          if (flush_cnt == '0) begin
            state_nxt = RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - FLUSH_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    fetch_valid = 1'b0;
    o_flushing  = 1'b0;
    case (state)
      RUN:     fetch_valid = !ckpt_full;
      FLUSH:   o_flushing  = 1'b1;
      default: ;
    endcase
    if (rst) begin
      fetch_valid = 1'b0;
    end
  end

  assign fire = fetch_valid && i_fetchReady && !i_correctValid &&
                (ckpt_count < (CKPT_AW+1)'(CKPT_DEPTH));

  always_comb begin
    action    = ras_action(i_predType_3);
    ras_upd   = ras_ptr;
    o_rasPush = 1'b0;
    o_rasPop  = 1'b0;
    if (fire) begin
      if (action[0]) begin
        o_rasPush = 1'b1;
        ras_upd   = ras_ptr + RAS_AW'(1);
      end else if (action[1]) begin
        o_rasPop  = 1'b1;
        ras_upd   = ras_ptr - RAS_AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ras_ptr <= '0;
    end else if (i_correctValid) begin
      pc <= i_correctPc_32;
      if (ckpt_live) begin
        ras_ptr <= ckpt_data;
      end
    end else if (fire) begin
      pc      <= i_predValid ? i_predPc_32 : pc + {{(PC_W-5){1'b0}}, i_blockSize_5};
      ras_ptr <= ras_upd;
    end
  end

  nbj_ckpt_fifo #(
    .DEPTH (CKPT_DEPTH),
    .AW    (CKPT_AW),
    .DW    (RAS_AW)
  ) u_ckpt (
    .clk       (clk),
    .rst       (rst),
    .push      (fire),
    .push_data (ras_upd),
    .pop       (i_commitValid),
    .trunc     (i_correctValid),
    .tag       (i_correctTag_3),
    .tag_data  (ckpt_data),
    .tag_live  (ckpt_live),
    .wr_ptr    (o_fetchTag_3),
    .count     (ckpt_count),
    .full      (ckpt_full)
  );

  assign o_fetchValid = fetch_valid;
  assign o_fetchPc_32 = pc;
  assign o_rasPtr_3   = ras_ptr;
  assign o_ckptFull   = ckpt_full;
  assign o_tagErr     = i_correctValid && !rst && !ckpt_live;

endmodule

// File: tb/tb_nbj_redirect_ctrl.sv
// Self-checking bench for nbj_redirect_ctrl: per-cycle vector table with a
// scoreboard queue, plus a hand-timed flush-latency sequence.
module tb_nbj_redirect_ctrl;

  typedef struct packed {
    logic        fetchValid;
    logic [31:0] fetchPc;
    logic [2:0]  fetchTag;
    logic        push;
    logic        pop;
    logic [2:0]  rasPtr;
    logic        flushing;
    logic        full;
    logic        tagErr;
    int          idx;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        ready;
    logic        predValid;
    logic [31:0] predPc;
    logic [2:0]  predType;
    logic [4:0]  blockSize;
    logic        commit;
    logic        corrValid;
    logic [31:0] corrPc;
    logic [2:0]  corrTag;
    logic        chk;
    exp_t        exp;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        fetchReady;
  logic        predValid;
  logic [31:0] predPc;
  logic [2:0]  predType;
  logic [4:0]  blockSize;
  logic        commitValid;
  logic        correctValid;
  logic [31:0] correctPc;
  logic [2:0]  correctTag;
  logic        fetchValid;
  logic [31:0] fetchPc;
  logic [2:0]  fetchTag;
  logic        rasPush;
  logic        rasPop;
  logic [2:0]  rasPtr;
  logic        flushing;
  logic        ckptFull;
  logic        tagErr;

  vec_t vecs[$];
  exp_t expQ[$];
  int   checks = 0;
  int   passed = 0;

  nbj_redirect_ctrl dut (
    .clk            (clock),
    .rst            (reset),
    .i_fetchReady   (fetchReady),
    .i_predValid    (predValid),
    .i_predPc_32    (predPc),
    .i_predType_3   (predType),
    .i_blockSize_5  (blockSize),
    .i_commitValid  (commitValid),
    .i_correctValid (correctValid),
    .i_correctPc_32 (correctPc),
    .i_correctTag_3 (correctTag),
    .o_fetchValid   (fetchValid),
    .o_fetchPc_32   (fetchPc),
    .o_fetchTag_3   (fetchTag),
    .o_rasPush      (rasPush),
    .o_rasPop       (rasPop),
    .o_rasPtr_3     (rasPtr),
    .o_flushing     (flushing),
    .o_ckptFull     (ckptFull),
    .o_tagErr       (tagErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic addVec(input int r, input int rdy, input int pv, input int ppc, input int pt,
                        input int cm, input int cv, input int cpc, input int ctag, input int chk,
                        input int ev, input int epc, input int etag, input int epush, input int epop,
                        input int eras, input int efl, input int efull, input int eerr);
    vec_t v;
    v.rst            = r[0];
    v.ready          = rdy[0];
    v.predValid      = pv[0];
    v.predPc         = ppc;
    v.predType       = pt[2:0];
    v.blockSize      = 5'd16;
    v.commit         = cm[0];
    v.corrValid      = cv[0];
    v.corrPc         = cpc;
    v.corrTag        = ctag[2:0];
    v.chk            = chk[0];
    v.exp.fetchValid = ev[0];
    v.exp.fetchPc    = epc;
    v.exp.fetchTag   = etag[2:0];
    v.exp.push       = epush[0];
    v.exp.pop        = epop[0];
    v.exp.rasPtr     = eras[2:0];
    v.exp.flushing   = efl[0];
    v.exp.full       = efull[0];
    v.exp.tagErr     = eerr[0];
    v.exp.idx        = 0;
    vecs.push_back(v);
  endtask

  // Drives one cycle of inputs and records what the outputs must show.
  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    reset        = v.rst;
    fetchReady   = v.ready;
    predValid    = v.predValid;
    predPc       = v.predPc;
    predType     = v.predType;
    blockSize    = v.blockSize;
    commitValid  = v.commit;
    correctValid = v.corrValid;
    correctPc    = v.corrPc;
    correctTag   = v.corrTag;
    if (v.chk) begin
      e     = v.exp;
      e.idx = idx;
      expQ.push_back(e);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) return;
    e = expQ.pop_front();
    cmp("fetchValid", e.idx, 32'(fetchValid), 32'(e.fetchValid));
    cmp("fetchPc",    e.idx, fetchPc,         e.fetchPc);
    cmp("fetchTag",   e.idx, 32'(fetchTag),   32'(e.fetchTag));
    cmp("rasPush",    e.idx, 32'(rasPush),    32'(e.push));
    cmp("rasPop",     e.idx, 32'(rasPop),     32'(e.pop));
    cmp("rasPtr",     e.idx, 32'(rasPtr),     32'(e.rasPtr));
    cmp("flushing",   e.idx, 32'(flushing),   32'(e.flushing));
    cmp("ckptFull",   e.idx, 32'(ckptFull),   32'(e.full));
    cmp("tagErr",     e.idx, 32'(tagErr),     32'(e.tagErr));
  endtask

  initial begin
    int latency;
    bit found;

    reset = 1'b1; fetchReady = 1'b0; predValid = 1'b0; predPc = '0; predType = '0;
    blockSize = 5'd16; commitValid = 1'b0; correctValid = 1'b0; correctPc = '0; correctTag = '0;

    // Columns: rst rdy pv predPc type commit cv corrPc tag | chk | valid pc tag push pop ras flush full err
    addVec(1,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0,0,0,0,0);
    addVec(1,0,0,0,0,0,0,0,0, 1, 0,0,0,0,0,0,0,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 0,'h0,0,0,0,0,0,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 1,'h00,0,0,0,0,0,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 1,'h10,1,0,0,0,0,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 1,'h20,2,0,0,0,0,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 1,'h30,3,0,0,0,0,0,0);
    addVec(0,1,1,'h100,4,0,0,0,0, 1, 1,'h40,4,1,0,0,0,0,0);
    addVec(0,1,1,'h44,5,0,0,0,0, 1, 1,'h100,5,0,1,1,0,0,0);
    addVec(0,0,0,0,4,0,0,0,0, 1, 1,'h44,6,0,0,0,0,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 1,'h44,6,0,0,0,0,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 1,'h54,7,0,0,0,0,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 0,'h64,0,0,0,0,0,1,0);
    addVec(0,1,0,0,0,1,0,0,0, 1, 0,'h64,0,0,0,0,0,1,0);
    addVec(0,0,0,0,0,0,0,0,0, 1, 1,'h64,0,0,0,0,0,0,0);
    addVec(1,0,0,0,0,0,0,0,0, 0, 0,0,0,0,0,0,0,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 0,0,0,0,0,0,0,0,0);
    addVec(0,1,1,'h100,4,0,0,0,0, 1, 1,0,0,1,0,0,0,0,0);
    addVec(0,1,1,'h180,4,0,0,0,0, 1, 1,'h100,1,1,0,1,0,0,0);
    addVec(0,1,1,'h1c0,4,0,0,0,0, 1, 1,'h180,2,1,0,2,0,0,0);
    addVec(0,1,1,'h1f0,4,0,1,'h200,0, 1, 1,'h1c0,3,0,0,3,0,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 0,'h200,1,0,0,1,1,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 0,'h200,1,0,0,1,1,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 1,'h200,1,0,0,1,0,0,0);
    addVec(0,0,0,0,0,0,1,'h300,5, 1, 1,'h210,2,0,0,1,0,0,1);
    addVec(0,1,0,0,0,0,1,'h400,1, 1, 0,'h300,2,0,0,1,1,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 0,'h400,2,0,0,1,1,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 0,'h400,2,0,0,1,1,0,0);
    addVec(0,0,0,0,0,0,1,'h700,1, 1, 1,'h400,2,0,0,1,0,0,0);
    addVec(1,0,0,0,0,0,0,0,0, 1, 0,'h700,2,0,0,1,1,0,0);
    addVec(0,1,0,0,0,0,0,0,0, 1, 0,0,0,0,0,0,0,0,0);
    addVec(0,1,1,'h500,5,1,0,0,0, 1, 1,0,0,0,1,0,0,0,0);
    addVec(0,1,0,0,0,0,1,'h600,0, 1, 1,'h500,1,0,0,7,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      applyStimulus(vecs[i], i);
      #4;
      checkOutput();
    end

    // The last vector issued a live correction; count cycles until fetch resumes.
    @(negedge clock);
    correctValid = 1'b0; commitValid = 1'b0; predValid = 1'b0; predType = 3'd0; fetchReady = 1'b0;
    found = 1'b0;
    latency = 0;
    for (int n = 1; n <= 10; n++) begin
      #4;
      if (fetchValid) begin
        found   = 1'b1;
        latency = n;
        break;
      end
      @(negedge clock);
    end
    if (!found) begin
      checks++;
      $display("[TB] FAIL flushLatency: fetchValid never returned within 10 cycles, expected 3");
    end else begin
      cmp("flushLatency", 99, 32'(latency), 32'd3);
      cmp("flushPc",      99, fetchPc,      32'h600);
      cmp("flushTag",     99, 32'(fetchTag), 32'd1);
      cmp("flushRasPtr",  99, 32'(rasPtr),   32'd7);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/nbj_redirect_ctrl.md
Name: nbj_redirect_ctrl

Overview:
- Sequences the fetch PC around the non-sequential-branch (nbj) next-PC datapath.
- Arbitrates three next-PC sources: backend correction, then nbj prediction, then sequential.
- Owns the return-address-stack pointer and drives push/pop to the datapath.
- Keeps an in-order checkpoint FIFO of post-block RAS pointers, so a backend correction restores the pointer and flushes the fetch pipe for a fixed number of cycles.

Parameters:
- RESET_PC, 32'h0, fetch PC loaded on reset.
- FLUSH_CYCLES, 2, cycles o_fetchValid is held low after a correction (≥1).
- CKPT_DEPTH, 8, checkpoint FIFO entries; power of two; tag width = log2(CKPT_DEPTH) = 3.
- RAS_DEPTH, 8, RAS entries; pointer width 3, wraps modulo depth.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_fetchReady  in  1  fetch stage accepts o_fetchPc this cycle.
- i_predValid  in  1  nbj datapath has a taken-branch next PC for the current block.
- i_predPc_32  in  32  predicted next PC.
- i_predType_3  in  3  branch type of the current block: 3=JALR, 4=CALL, 5=RET, other=none.
- i_blockSize_5  in  5  valid bytes in the current block (sequential increment).
- i_commitValid  in  1  oldest in-flight block retired.
- i_correctValid  in  1  backend misprediction.
- i_correctPc_32  in  32  corrected PC.
- i_correctTag_3  in  3  checkpoint tag of the mispredicted block.
- o_fetchValid  out  1  o_fetchPc is a request.
- o_fetchPc_32  out  32  current fetch PC.
- o_fetchTag_3  out  3  checkpoint tag assigned to this block.
- o_rasPush  out  1  one-cycle pulse: datapath writes RAS[o_rasPtr+1].
- o_rasPop  out  1  one-cycle pulse: datapath reads RAS[o_rasPtr].
- o_rasPtr_3  out  3  current RAS top pointer.
- o_flushing  out  1  high in FLUSH.
- o_ckptFull  out  1  checkpoint FIFO full.
- o_tagErr  out  1  one-cycle pulse: correction carried a tag that is not in flight.

Behaviour:
- Reset (synchronous): state=IDLE; pc=RESET_PC; rasPtr=0; FIFO wr=rd=count=0; all outputs 0; o_fetchPc=RESET_PC. Reset wins over every other input, including mid-FLUSH.
- States:
  - IDLE: one cycle, o_fetchValid=0, then RUN.
  - RUN: o_fetchValid=!o_ckptFull.
  - FLUSH: counter loads FLUSH_CYCLES-1 and counts down; o_fetchValid=0; exits to RUN when counter==0.
- Fire: o_fetchValid & i_fetchReady. Requires count<CKPT_DEPTH.
- On fire, next cycle:
  - pc = i_predValid ? i_predPc : pc + zero-extended i_blockSize (32-bit wrap).
  - Pointer update by type:
    - CALL: o_rasPush pulses in the fire cycle (combinational); rasPtr+1.
    - RET: o_rasPop pulses; rasPtr-1.
    - JALR/other: rasPtr unchanged.
  - FIFO[wr] stores the post-update rasPtr; o_fetchTag = wr; wr+1; count+1.
- No fire: pc, rasPtr and the FIFO hold; push/pop stay 0.
- Commit: rd+1, count-1. Ignored when count==0.
- Correction (any state except reset; highest priority; overrides a same-cycle fire, which is dropped):
  - Same-cycle commit is applied first.
  - Tag is live when it lies in [rd, wr) modulo depth, given count>0.
  - Live tag: rasPtr=FIFO[tag]; wr=tag+1; count recomputed as (tag-rd)+1.
  - Dead tag: rasPtr and FIFO unchanged; o_tagErr pulses.
  - In both cases: pc=i_correctPc; enter FLUSH.
  - A correction during FLUSH restarts the counter.
- Full: o_ckptFull = (count==CKPT_DEPTH). o_fetchValid=0 while full. A commit in a full cycle frees an entry; fetch resumes the next cycle.
- Pointer arithmetic is modulo RAS_DEPTH; overflow/underflow wrap silently.
- Latency: prediction or correction to new o_fetchPc is 1 cycle. Correction to o_fetchValid=1 is FLUSH_CYCLES+1 cycles.

Decomposition:
- Package nbj_pkg holds:
  - type codes JALR=3'd3, CALL=3'd4, RET=3'd5;
  - state enum IDLE/RUN/FLUSH;
  - width constants PC_W=32, TAG_W=3.
- One sub-module, nbj_ckpt_fifo, owns the FIFO:
  - write, pop, truncate-to-tag and random read by tag;
  - live-tag check;
  - count/full outputs.

Test Plan:
- Reset then ready=1, no pred, blockSize=16 → o_fetchPc 0, 0x10, 0x20 on consecutive cycles; tags 0, 1, 2; o_fetchValid low only in the IDLE cycle.
- CALL at pc 0x40 with predPc 0x100, then RET with predPc 0x44 → o_rasPush pulse and rasPtr 0→1, then o_rasPop pulse and rasPtr 1→0; fetch PCs 0x100 then 0x44.
- Eight fires without commit → o_ckptFull=1 and o_fetchValid=0. One commit → full clears; fetch resumes next cycle with tag 0.
- Three CALLs (tags 0–2, ptr 1, 2, 3) then correction tag=0, pc=0x200 → rasPtr=1, count=1; o_fetchValid low for 2 cycles; then 0x200 issued with tag 1.
- Correction with a dead tag (e.g. tag 5 while count=2) → o_tagErr pulse, pc redirected, rasPtr unchanged. Reset asserted during FLUSH → IDLE with pc=RESET_PC next cycle.
